forwarding_scoreboard: RTL
==========================

// Module: forwarding_scoreboard
// PURPOSE
//  Parametrised operand-bypass and hazard unit for the in-order pipeline. Tracks
//  in-flight register writers in a shift register, one slot per stage from EX
//  onward, plus a pending-bit scoreboard for the variable-latency multiplier.
//  Returns forwarded operand data for the EX-stage instruction and raises stall
//  on load-use and multiplier RAW/WAW hazards. Sits beside the EX stage.
// PARAMETERS
//  DATA_W      32  datapath width
//  REGS        32  architectural registers; REG_W = $clog2(REGS); reg 0 hardwired 0
//  STAGES      3   tracker slots: slot0=EX, slot1=MEM, slot2=WB (>=2)
//  READ_PORTS  2   source operands queried per cycle
//  LOAD_STAGE  1   slot whose late (load) result is not yet forwardable
// PORTS
//  CLK         in   1                   clock
//  nRST        in   1                   async reset, active low
//  issue_valid in   1                   instruction enters EX on this advance
//  issue_wen   in   1                   it writes a register
//  issue_late  in   1                   result produced at end of LOAD_STAGE (load)
//  issue_dst   in   REG_W               its destination
//  advance     in   1                   whole pipeline shifts this cycle
//  bubble      in   1                   EX holds, slots>=1 shift, invalid into slot1
//  flush       in   1                   squash slot0 and the incoming issue
//  stage_data  in   STAGES*DATA_W       result of instruction in each slot (slot0 unused)
//  src_addr    in   READ_PORTS*REG_W    EX-instruction source registers
//  src_used    in   READ_PORTS          source actually read
//  mul_issue   in   1                   multiplier op launched (dst = mul_dst)
//  mul_dst     in   REG_W               multiplier destination
//  mul_done    in   1                   multiplier result written back this cycle
//  fwd_en      out  READ_PORTS          operand p taken from bypass, not regfile
//  fwd_data    out  READ_PORTS*DATA_W   bypassed operand p ('0 when !fwd_en)
//  hazard_stall out 1                   hold EX and earlier; insert bubble
//  mul_busy    out  1                   any scoreboard bit set
// BEHAVIOUR
//  Reset (nRST low, any time): all slots invalid, scoreboard cleared;
//   fwd_en=0, fwd_data='0, hazard_stall=0, mul_busy=0 combinationally thereafter.
//  Slot state {valid, wen, late, dst}; only state is slots + REGS-bit pending vector.
//  Update, priority flush > advance > bubble:
//   flush: slot0 <= invalid; if advance also, slots shift and slot1 <= invalid.
//   advance: slot[s] <= slot[s-1] for s>=1; slot0 <= issue (valid = issue_valid).
//   bubble (advance=0): slot[s] <= slot[s-1] for s>=2; slot1 <= invalid; slot0 holds.
//   neither: all hold. Last slot drops off (regfile now holds value).
//  Forwarding, combinational, per port p with src_used[p], src_addr[p]!=0:
//   match[s] = slot[s].valid & wen & dst==src_addr[p], s in 1..STAGES-1.
//   Youngest (lowest s) match wins; fwd_en=1, fwd_data=stage_data[s].
//   If winner has late=1 and s<=LOAD_STAGE: load-use -> hazard_stall=1.
//  Scoreboard: mul_issue sets pending[mul_dst]; mul_done clears pending[dst of op];
//   one multiplier op outstanding, so unit latches mul_dst at issue. Set+clear same
//   reg same cycle: set wins. mul_dst==0 never sets.
//   pending[src_addr[p]] for a used port -> hazard_stall=1 (RAW).
//   issue_valid & issue_wen & pending[issue_dst] -> hazard_stall=1 (WAW).
//   mul_done cycle: regfile write-through makes value visible; no stall that cycle.
//  hazard_stall is purely combinational from state + inputs; no latency added.
//  Register 0: never matches, never forwarded, never stalls.
// STRUCTURE
//  cpu_types_pkg gains: fwd_slot_t struct {valid,wen,late,dst}; regbits_t reused.
//  One sub-module: fwd_port_select (per-port priority match/mux over slots),
//  instantiated READ_PORTS times via generate; tracker + scoreboard stay top level.
// TESTING
//  ALU chain: add r3 then sub r4,r3 next cycle -> port0 fwd_en=1, data=slot1 value.
//  Two writers r5 in slot1 and slot2 (0xA,0xB) -> fwd_data=0xA (youngest).
//  lw r7 in slot1, EX reads r7 -> hazard_stall=1; after bubble, slot2 fwd, stall=0.
//  mul_issue r9, EX reads r9 -> stall until mul_done; same cycle stall=0, mul_busy=0.
//  flush with advance: slot1 invalid next cycle, no forward from squashed r6.
//  nRST low mid-mul with pending r9: next cycle mul_busy=0, no stall on r9; r0 never fwd.

Source files
------------

// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types for the EX-stage bypass/hazard unit: tracker slot record,
// register bit-vector and a one-hot helper that keeps r0 permanently clear.
package forwarding_scoreboard_pkg;

    localparam int unsigned CPU_REGS  = 32;
    localparam int unsigned CPU_REG_W = $clog2(CPU_REGS);

    typedef logic [CPU_REGS-1:0]  regbits_t;
    typedef logic [CPU_REG_W-1:0] reg_idx_t;

    // One in-flight writer tracked per pipeline slot
    typedef struct packed {
        logic     valid;
        logic     wen;
        logic     late;
        reg_idx_t dst;
    } fwd_slot_t;

    // One-hot register mask; r0 maps to an empty mask so it can never be marked pending
    function automatic regbits_t reg_bit(input reg_idx_t idx);
        regbits_t b;
        b = '0;
        if (idx != '0) begin
            b[idx] = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/forwarding_scoreboard_fwd_port_select.sv
// Per-read-port bypass selector: finds the youngest valid writer of the source
// register among slots 1..STAGES-1 and flags a load-use hazard when that writer's
// result is produced too late to forward.
module fwd_port_select
    import forwarding_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 1
) (
    // Element i describes tracker slot i+1 (slot0 is the consumer itself)
    input  fwd_slot_t [STAGES-2:0]        slots,
    input  logic [(STAGES-1)*DATA_W-1:0]  stage_data,
    input  reg_idx_t                      src_addr,
    input  logic                          src_used,
    output logic                          fwd_en,
    output logic [DATA_W-1:0]             fwd_data,
    output logic                          load_use
);

    logic hit;

    // Priority scan from the youngest slot; the first match owns the operand
    always_comb begin
        hit      = 1'b0;
        fwd_en   = 1'b0;
        fwd_data = '0;
        load_use = 1'b0;
        if (src_used && (src_addr != '0)) begin
            for (int unsigned i = 0; i < STAGES - 1; i++) begin
                if (!hit && slots[i].valid && slots[i].wen && (slots[i].dst == src_addr)) begin
                    hit      = 1'b1;
                    fwd_en   = 1'b1;
                    fwd_data = stage_data[i*DATA_W +: DATA_W];
                    load_use = slots[i].late && ((i + 1) <= LOAD_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Operand-bypass and hazard unit beside EX: a shift-register tracker of in-flight
// writers (slot0=EX onward) plus a pending-bit scoreboard for the multiplier.
// REGS must match CPU_REGS from the package since slot and scoreboard types use it.
module forwarding_scoreboard
    import forwarding_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REGS       = CPU_REGS,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned READ_PORTS = 2,
    parameter int unsigned LOAD_STAGE = 1,
    localparam int unsigned REG_W     = $clog2(REGS)
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         issue_valid,
    input  logic                         issue_wen,
    input  logic                         issue_late,
    input  logic [REG_W-1:0]             issue_dst,
    input  logic                         advance,
    input  logic                         bubble,
    input  logic                         flush,
    input  logic [STAGES*DATA_W-1:0]     stage_data,
    input  logic [READ_PORTS*REG_W-1:0]  src_addr,
    input  logic [READ_PORTS-1:0]        src_used,
    input  logic                         mul_issue,
    input  logic [REG_W-1:0]             mul_dst,
    input  logic                         mul_done,
    output logic [READ_PORTS-1:0]        fwd_en,
    output logic [READ_PORTS*DATA_W-1:0] fwd_data,
    output logic                         hazard_stall,
    output logic                         mul_busy
);

    fwd_slot_t [STAGES-1:0] slot_q, slot_d;
    fwd_slot_t              issue_slot;
    regbits_t               pending_q, pending_d, pending_eff;
    reg_idx_t               mul_dst_q;
    logic [READ_PORTS-1:0]  load_use;
    logic                   raw_stall;
    logic                   waw_stall;

    // The EX instruction's own result never feeds itself; slot0 data is unused
    logic unused_slot0_data;
    assign unused_slot0_data = ^stage_data[DATA_W-1:0];

    assign issue_slot = '{valid: issue_valid, wen: issue_wen, late: issue_late, dst: issue_dst};

    // Tracker next state, priority flush > advance > bubble > hold
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d[0] = '0;
            if (advance) begin
                for (int unsigned s = 2; s < STAGES; s++) begin
                    slot_d[s] = slot_q[s-1];
                end
                // The squashed EX instruction must not reach MEM as a live writer
                slot_d[1] = '0;
            end
        end else if (advance) begin
            for (int unsigned s = 1; s < STAGES; s++) begin
                slot_d[s] = slot_q[s-1];
            end
            slot_d[0] = issue_slot;
        end else if (bubble) begin
            for (int unsigned s = 2; s < STAGES; s++) begin
                slot_d[s] = slot_q[s-1];
            end
            slot_d[1] = '0;
        end
    end

    // Scoreboard: completion clears the latched destination, a new launch sets (set wins)
    always_comb begin
        pending_eff = pending_q;
        if (mul_done) begin
            pending_eff = pending_q & ~reg_bit(mul_dst_q);
        end
        pending_d = pending_eff;
        if (mul_issue) begin
            pending_d = pending_eff | reg_bit(mul_dst);
        end
    end

    // Tracker, scoreboard and outstanding multiplier destination
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            slot_q    <= '0;
            pending_q <= '0;
            mul_dst_q <= '0;
        end else begin
            slot_q    <= slot_d;
            pending_q <= pending_d;
            if (mul_issue) begin
                mul_dst_q <= mul_dst;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        fwd_port_select #(
            .DATA_W     (DATA_W),
            .STAGES     (STAGES),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_sel (
            .slots      (slot_q[STAGES-1:1]),
            .stage_data (stage_data[STAGES*DATA_W-1:DATA_W]),
            .src_addr   (src_addr[p*REG_W +: REG_W]),
            .src_used   (src_used[p]),
            .fwd_en     (fwd_en[p]),
            .fwd_data   (fwd_data[p*DATA_W +: DATA_W]),
            .load_use   (load_use[p])
        );
    end

    // RAW on a pending multiplier result; the completing register is already visible
    always_comb begin
        raw_stall = 1'b0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            if (src_used[p] && pending_eff[src_addr[p*REG_W +: REG_W]]) begin
                raw_stall = 1'b1;
            end
        end
    end

    // WAW: a new writer must not overtake an outstanding multiplier write
    assign waw_stall = issue_valid && issue_wen && pending_eff[issue_dst];

    assign hazard_stall = raw_stall || waw_stall || (|load_use);
    assign mul_busy     = |pending_eff;

endmodule
